// File: rtl/aidan_mcnay_prime_pkg.sv
// Shared state encoding and defaults for the trial-division primality controller.
package aidan_mcnay_prime_pkg;

   localparam int unsigned ODD_SKIP_DEFAULT = 1;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIV_REQ,
      DIV_RESP,
      NEXT,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/aidan_mcnay_trial_div_counter.sv
// Trial divisor and its running square; the square is stepped incrementally,
// so no multiplier is needed.
module aidan_mcnay_trial_div_counter #(
   parameter int unsigned NBITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               odd_skip,
   output logic [NBITS-1:0]   divisor,
   output logic [2*NBITS-1:0] sq
);

   logic [NBITS-1:0]   div_q, div_d;
   logic [2*NBITS-1:0] sq_q, sq_d;
   logic [2*NBITS-1:0] d_ext;
   logic               big_step;

   always_comb begin
      d_ext    = {{NBITS{1'b0}}, div_q};
      big_step = odd_skip && (div_q != NBITS'(2));
      div_d    = div_q;
      sq_d     = sq_q;
      if (load) begin
         div_d = NBITS'(2);
         sq_d  = (2*NBITS)'(4);
      end else if (step) begin
         // (d+2)^2 = d^2 + 4d + 4 ; (d+1)^2 = d^2 + 2d + 1
         if (big_step) begin
            div_d = div_q + NBITS'(2);
            sq_d  = sq_q + (d_ext << 2) + (2*NBITS)'(4);
         end else begin
            div_d = div_q + NBITS'(1);
            sq_d  = sq_q + (d_ext << 1) + (2*NBITS)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
         sq_q  <= '0;
      end else begin
         div_q <= div_d;
         sq_q  <= sq_d;
      end
   end

   assign divisor = div_q;
   assign sq      = sq_q;

endmodule

// File: rtl/aidan_mcnay_prime_ctrl.sv
// Primality tester by trial division against an external streaming divider,
// stopping once divisor^2 exceeds the value under test.
module aidan_mcnay_prime_ctrl
   import aidan_mcnay_prime_pkg::*;
#(
   parameter int unsigned NBITS    = 16,
   parameter int unsigned ODD_SKIP = ODD_SKIP_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [NBITS-1:0] req_value,
   input  logic             abort,
   output logic             div_istream_val,
   input  logic             div_istream_rdy,
   output logic [NBITS-1:0] div_dividend,
   output logic [NBITS-1:0] div_divisor,
   input  logic             div_ostream_val,
   output logic             div_ostream_rdy,
   input  logic [NBITS-1:0] div_remainder,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic             is_prime,
   output logic [NBITS-1:0] factor,
   output logic             busy
);

   state_e             state_q, state_d;
   logic [NBITS-1:0]   value_q, value_d;
   logic               is_prime_q, is_prime_d;
   logic [NBITS-1:0]   factor_q, factor_d;
   logic               cnt_load, cnt_step;
   logic [NBITS-1:0]   divisor;
   logic [2*NBITS-1:0] sq;

   aidan_mcnay_trial_div_counter #(
      .NBITS (NBITS)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .step     (cnt_step),
      .odd_skip (ODD_SKIP != 0),
      .divisor  (divisor),
      .sq       (sq)
   );

   always_comb begin
      state_d         = state_q;
      value_d         = value_q;
      is_prime_d      = is_prime_q;
      factor_d        = factor_q;
      cnt_load        = 1'b0;
      cnt_step        = 1'b0;
      req_rdy         = 1'b0;
      div_istream_val = 1'b0;
      div_ostream_rdy = 1'b0;
      resp_val        = 1'b0;
      busy            = (state_q != IDLE);
      div_dividend    = value_q;
      div_divisor     = divisor;
      is_prime        = is_prime_q;
      factor          = factor_q;

      case (state_q)
         IDLE: begin
            req_rdy = 1'b1;
            if (req_val) begin
               value_d  = req_value;
               cnt_load = 1'b1;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
            end else if (value_q < NBITS'(2)) begin
               is_prime_d = 1'b0;
               factor_d   = '0;
               state_d    = DONE;
            end else if (sq > {{NBITS{1'b0}}, value_q}) begin
               is_prime_d = 1'b1;
               factor_d   = value_q;
               state_d    = DONE;
            end else begin
               state_d = DIV_REQ;
            end
         end
         DIV_REQ: begin
            div_istream_val = 1'b1;
            // A request accepted in the abort cycle still owes a response.
            if (div_istream_rdy) state_d = abort ? DRAIN : DIV_RESP;
            else if (abort)      state_d = IDLE;
         end
         DIV_RESP: begin
            div_ostream_rdy = 1'b1;
            if (abort) begin
               state_d = div_ostream_val ? IDLE : DRAIN;
            end else if (div_ostream_val) begin
               if (div_remainder == '0) begin
                  is_prime_d = 1'b0;
                  factor_d   = divisor;
                  state_d    = DONE;
               end else begin
                  state_d = NEXT;
               end
            end
         end
         NEXT: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               cnt_step = 1'b1;
               state_d  = CHECK;
            end
         end
         DRAIN: begin
            div_ostream_rdy = 1'b1;
            if (div_ostream_val) state_d = IDLE;
         end
         DONE: begin
            resp_val = 1'b1;
            if (resp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (reset) begin
         req_rdy         = 1'b0;
         div_istream_val = 1'b0;
         div_ostream_rdy = 1'b0;
         resp_val        = 1'b0;
         busy            = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         value_q    <= '0;
         is_prime_q <= 1'b0;
         factor_q   <= '0;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         is_prime_q <= is_prime_d;
         factor_q   <= factor_d;
      end
   end

endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl.sv
// Bench for aidan_mcnay_prime_ctrl: instance 0 with ODD_SKIP=1, instance 1 with
// ODD_SKIP=0, each driven by a small behavioural divider with optional stalls.
module tb_aidan_mcnay_prime_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_val[2], req_rdy[2], abort[2];
   logic [15:0] req_value[2];
   logic        div_istream_val[2], irdy[2], ov[2], div_ostream_rdy[2];
   logic [15:0] div_dividend[2], div_divisor[2], rem[2];
   logic        resp_val[2], resp_rdy[2], is_prime[2], busy[2];
   logic [15:0] factor[2];
   logic        pend[2];
   int          wt[2];
   int          stall_mode[2];   // 0 zero-wait, 1 random stalls, 2 fixed 3-cycle response delay

   int checks = 0;
   int errors = 0;
   int dseq[8];

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         aidan_mcnay_prime_ctrl #(
            .NBITS    (16),
            .ODD_SKIP ((gi == 0) ? 1 : 0)
         ) dut (
            .clk             (clk),
            .reset           (reset),
            .req_val         (req_val[gi]),
            .req_rdy         (req_rdy[gi]),
            .req_value       (req_value[gi]),
            .abort           (abort[gi]),
            .div_istream_val (div_istream_val[gi]),
            .div_istream_rdy (irdy[gi]),
            .div_dividend    (div_dividend[gi]),
            .div_divisor     (div_divisor[gi]),
            .div_ostream_val (ov[gi]),
            .div_ostream_rdy (div_ostream_rdy[gi]),
            .div_remainder   (rem[gi]),
            .resp_val        (resp_val[gi]),
            .resp_rdy        (resp_rdy[gi]),
            .is_prime        (is_prime[gi]),
            .factor          (factor[gi]),
            .busy            (busy[gi])
         );
      end
   endgenerate

   // Divider model, reset together with the controllers.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (reset) begin
            irdy[g] <= 1'b1;
            ov[g]   <= 1'b0;
            pend[g] <= 1'b0;
            wt[g]   <= 0;
            rem[g]  <= '0;
         end else begin
            irdy[g] <= (stall_mode[g] == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (ov[g] && div_ostream_rdy[g]) ov[g] <= 1'b0;
            if (pend[g]) begin
               if (wt[g] == 0) begin
                  ov[g]   <= 1'b1;
                  pend[g] <= 1'b0;
               end else begin
                  wt[g] <= wt[g] - 1;
               end
            end
            if (div_istream_val[g] && irdy[g]) begin
               rem[g] <= div_dividend[g] % div_divisor[g];
               if (stall_mode[g] == 0) begin
                  ov[g] <= 1'b1;
               end else begin
                  pend[g] <= 1'b1;
                  wt[g]   <= (stall_mode[g] == 1) ? int'($urandom_range(0, 3)) : 2;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input int g, input int unsigned v);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_rdy[g] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("req_rdy_wait", 32'(req_rdy[g]), 1);
      req_val[g]   = 1'b1;
      req_value[g] = v[15:0];
      @(posedge clk);
      @(negedge clk);
      req_val[g] = 1'b0;
   endtask

   task automatic run(input int g, input int unsigned v, input int rdly,
                      output int nd, output int unsigned mx, output logic pr,
                      output logic [15:0] fc, output int lat, output bit stable);
      int cyc;
      bit tmo;
      nd = 0; mx = 0; stable = 1'b1; cyc = 1; tmo = 1'b0;
      for (int i = 0; i < 8; i++) dseq[i] = 0;
      send(g, v);
      while (!resp_val[g]) begin
         if (div_istream_val[g] && irdy[g]) begin
            if (nd < 8) dseq[nd] = int'(div_divisor[g]);
            nd++;
            if (div_divisor[g] > mx) mx = div_divisor[g];
         end
         if (cyc > 20000) begin
            tmo = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      chk("resp_timeout", 32'(tmo), 0);
      lat = cyc;
      pr  = is_prime[g];
      fc  = factor[g];
      for (int k = 0; k < rdly; k++) begin
         @(negedge clk);
         if (resp_val[g] !== 1'b1 || is_prime[g] !== pr || factor[g] !== fc) stable = 1'b0;
      end
      resp_rdy[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_rdy[g] = 1'b0;
      $display("tx inst=%0d value=%0d is_prime=%0b factor=%0d divisions=%0d latency=%0d",
               g, v, pr, fc, nd, lat);
   endtask

   typedef struct {
      int          g;
      int          mode;
      int unsigned value;
      logic        exp_prime;
      int unsigned exp_factor;
      int          exp_nd;
      int          exp_lat;    // -1: not checked
      int          rdly;       // cycles resp_rdy is held low
      int unsigned max_div;    // 0: not checked
      int          s0, s1, s2, s3;  // first four divisors, all 0: not checked
   } vec_t;

   vec_t vecs[13];

   initial begin
      int nd, lat, n, consumed;
      int unsigned mx;
      logic pr;
      logic [15:0] fc;
      bit stable, saw_resp;

      vecs[0]  = '{0, 0, 97,    1'b1, 97,    5,   -1, 0,  0,   2, 3, 5, 7};
      vecs[1]  = '{0, 0, 91,    1'b0, 7,     4,   -1, 0,  0,   2, 3, 5, 7};
      vecs[2]  = '{0, 0, 4,     1'b0, 2,     1,   -1, 0,  0,   0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0,     1'b0, 0,     0,    2, 0,  0,   0, 0, 0, 0};
      vecs[4]  = '{0, 0, 1,     1'b0, 0,     0,    2, 0,  0,   0, 0, 0, 0};
      vecs[5]  = '{0, 0, 2,     1'b1, 2,     0,    2, 0,  0,   0, 0, 0, 0};
      vecs[6]  = '{0, 0, 3,     1'b1, 3,     0,    2, 0,  0,   0, 0, 0, 0};
      vecs[7]  = '{0, 1, 65521, 1'b1, 65521, 128, -1, 10, 257, 2, 3, 5, 7};
      vecs[8]  = '{1, 0, 25,    1'b0, 5,     4,   -1, 0,  0,   2, 3, 4, 5};
      vecs[9]  = '{1, 0, 97,    1'b1, 97,    8,   -1, 3,  0,   2, 3, 4, 5};
      vecs[10] = '{0, 0, 49,    1'b0, 7,     4,   -1, 0,  0,   2, 3, 5, 7};
      vecs[11] = '{1, 0, 65535, 1'b0, 3,     2,   -1, 0,  0,   0, 0, 0, 0};
      vecs[12] = '{0, 1, 91,    1'b0, 7,     4,   -1, 5,  0,   2, 3, 5, 7};

      reset = 1'b1;
      for (int g = 0; g < 2; g++) begin
         req_val[g] = 1'b0; req_value[g] = '0; abort[g] = 1'b0; resp_rdy[g] = 1'b0;
         stall_mode[g] = 0;
      end

      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("rst_req_rdy",   32'(req_rdy[g]), 0);
         chk("rst_resp_val",  32'(resp_val[g]), 0);
         chk("rst_istream",   32'(div_istream_val[g]), 0);
         chk("rst_ostream",   32'(div_ostream_rdy[g]), 0);
         chk("rst_busy",      32'(busy[g]), 0);
         chk("rst_is_prime",  32'(is_prime[g]), 0);
         chk("rst_factor",    32'(factor[g]), 0);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_req_rdy", 32'(req_rdy[0]), 1);

      for (int i = 0; i < 13; i++) begin
         stall_mode[vecs[i].g] = vecs[i].mode;
         run(vecs[i].g, vecs[i].value, vecs[i].rdly, nd, mx, pr, fc, lat, stable);
         chk("is_prime", 32'(pr), 32'(vecs[i].exp_prime));
         chk("factor", 32'(fc), vecs[i].exp_factor);
         chk("divisions", nd, vecs[i].exp_nd);
         if (vecs[i].exp_lat >= 0) chk("latency", lat, vecs[i].exp_lat);
         if (vecs[i].rdly > 0) chk("resp_stable", 32'(stable), 1);
         if (vecs[i].max_div > 0) chk("max_divisor_bound", 32'(mx <= vecs[i].max_div), 1);
         if (vecs[i].s3 != 0) begin
            chk("div_seq0", dseq[0], vecs[i].s0);
            chk("div_seq1", dseq[1], vecs[i].s1);
            chk("div_seq2", dseq[2], vecs[i].s2);
            chk("div_seq3", dseq[3], vecs[i].s3);
         end
      end

      // Abort while waiting on a delayed divider response: must drain it silently.
      stall_mode[0] = 2;
      send(0, 97);
      n = 0;
      while (!(div_ostream_rdy[0] && !ov[0]) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_div_resp", 32'(div_ostream_rdy[0] && !ov[0]), 1);
      abort[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort[0] = 1'b0;
      consumed = 0; saw_resp = 1'b0; n = 0;
      while (busy[0] && n < 50) begin
         if (ov[0] && div_ostream_rdy[0]) consumed++;
         if (resp_val[0]) saw_resp = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("drain_idle", 32'(busy[0]), 0);
      chk("drain_consumed", consumed, 1);
      chk("drain_no_resp", 32'(saw_resp), 0);
      chk("drain_div_quiet", 32'(ov[0]), 0);
      $display("tx inst=0 value=97 aborted in DIV_RESP, responses drained=%0d", consumed);

      stall_mode[0] = 0;
      run(0, 15, 0, nd, mx, pr, fc, lat, stable);
      chk("after_abort_factor", 32'(fc), 3);
      chk("after_abort_prime", 32'(pr), 0);

      // Abort in CHECK returns straight to IDLE.
      send(0, 97);
      abort[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort_check_idle", 32'(req_rdy[0]), 1);
      chk("abort_check_no_resp", 32'(resp_val[0]), 0);
      $display("tx inst=0 value=97 aborted in CHECK");

      // Abort coinciding with the divider handshake drains the owed response.
      send(0, 97);
      n = 0;
      while (!div_istream_val[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_div_req", 32'(div_istream_val[0]), 1);
      abort[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort_hs_busy", 32'(busy[0]), 1);
      chk("abort_hs_ostream_rdy", 32'(div_ostream_rdy[0]), 1);
      @(negedge clk);
      chk("abort_hs_idle", 32'(req_rdy[0]), 1);
      chk("abort_hs_no_resp", 32'(resp_val[0]), 0);
      $display("tx inst=0 value=97 aborted with divider handshake");

      // Reset in DIV_REQ clears every output on the next cycle.
      send(0, 97);
      n = 0;
      while (!div_istream_val[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_div_req2", 32'(div_istream_val[0]), 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_req_rdy",  32'(req_rdy[0]), 0);
      chk("mid_rst_resp_val", 32'(resp_val[0]), 0);
      chk("mid_rst_istream",  32'(div_istream_val[0]), 0);
      chk("mid_rst_ostream",  32'(div_ostream_rdy[0]), 0);
      chk("mid_rst_busy",     32'(busy[0]), 0);
      chk("mid_rst_is_prime", 32'(is_prime[0]), 0);
      chk("mid_rst_factor",   32'(factor[0]), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_recover_idle", 32'(req_rdy[0]), 1);
      $display("tx inst=0 value=97 reset in DIV_REQ");

      run(0, 4, 0, nd, mx, pr, fc, lat, stable);
      chk("post_rst_factor", 32'(fc), 2);
      chk("post_rst_divisions", nd, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
